// File: rtl/dac_sample_pacer.sv
// Sample FIFO and rate pacer feeding a 10-bit DAC: buffers writer samples and
// emits one every DIV clocks with a DCLKIO strobe, power-down control and underrun flag.
module dac_sample_pacer #(
  parameter int unsigned DW          = 10,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DIV         = 4,
  parameter int unsigned PRIME_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DW-1:0]            s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [DW-1:0]            dac_data,
  output logic                     dac_dclkio,
  output logic                     dac_pwrdn,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underrun,
  input  logic                     underrun_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DIV);
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   PRIME_LVL = (AW+1)'(PRIME_LEVEL);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          wrap;
  logic          half;

  assign s_ready    = (fifo_level < FULL_LVL);
  assign push       = s_valid & s_ready;
  assign fifo_empty = (fifo_level == '0);
  // wrap marks the edge where cnt would become 0; enable is only honoured here
  assign wrap       = (state == RUN) && (cnt == CNT_LAST);
  assign half       = (state == RUN) && (cnt == CNT_HALF);
  assign pop        = wrap & enable & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      dac_data   <= '0;
      dac_dclkio <= 1'b0;
      dac_pwrdn  <= 1'b1;
      underrun   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase

      // Set below overrides this clear when both land on the same edge
      if (underrun_clr) underrun <= 1'b0;

      case (state)
        IDLE: begin
          dac_dclkio <= 1'b0;
          dac_pwrdn  <= 1'b1;
          if (enable) begin
            state     <= PRIME;
            dac_pwrdn <= 1'b0;
          end
        end
        PRIME: begin
          if (!enable) begin
            state     <= IDLE;
            dac_pwrdn <= 1'b1;
          end else if (fifo_level >= PRIME_LVL) begin
            state <= RUN;
            cnt   <= CNT_LAST;
          end
        end
        RUN: begin
          if (wrap) begin
            cnt        <= '0;
            dac_dclkio <= 1'b0;
            if (!enable) begin
              state     <= IDLE;
              dac_pwrdn <= 1'b1;
            end else if (fifo_empty) begin
              underrun <= 1'b1;
            end else begin
              dac_data <= mem[rd_ptr];
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (half) dac_dclkio <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Scoreboard bench for dac_sample_pacer: pushed samples are queued as expected
// strobe data; a negedge monitor checks each rising DCLKIO against the queue.
module tb_dac_sample_pacer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [9:0] dac_data;
  logic       dac_dclkio;
  logic       dac_pwrdn;
  logic [4:0] fifo_level;
  logic       underrun;
  logic       underrun_clr = 1'b0;

  dac_sample_pacer #(.DW(10), .DEPTH(16), .DIV(DIV), .PRIME_LEVEL(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .dac_data     (dac_data),
    .dac_dclkio   (dac_dclkio),
    .dac_pwrdn    (dac_pwrdn),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] v);
    check("push_ready", s_ready, 1'b1);
    s_data  = v;
    s_valid = 1'b1;
    tick(1);
    s_valid = 1'b0;
    exp_q.push_back(v);
  endtask

  // Monitor: compares data at each rising DCLKIO; with an empty queue the
  // DAC must hold the last sample. Also checks strobe lead and period.
  int         cyc = 0;
  int         last_rise = -1;
  int         chg_cyc = 0;
  logic       prev_dclk = 1'b0;
  logic [9:0] prev_data = '0;
  logic [9:0] last_exp = '0;

  always @(negedge clk) begin
    cyc++;
    if (dac_data !== prev_data) chg_cyc = cyc;
    prev_data = dac_data;
    if (dac_pwrdn) begin
      last_rise = -1;
      prev_dclk = 1'b0;
    end else begin
      if (dac_dclkio && !prev_dclk) begin
        if (exp_q.size() > 0) last_exp = exp_q.pop_front();
        check("strobe_data", dac_data, last_exp);
        if (last_rise < 0) check("strobe_lead", cyc - chg_cyc, DIV / 2);
        else               check("strobe_period", cyc - last_rise, DIV);
        last_rise = cyc;
      end
      prev_dclk = dac_dclkio;
    end
  end

  initial begin
    int acc;
    logic rdy;
    logic [9:0] v;

    // 1: reset state
    tick(3);
    rst = 1'b1;
    tick(1);
    check("rst_pwrdn", dac_pwrdn, 1'b1);
    check("rst_dclk", dac_dclkio, 1'b0);
    check("rst_data", dac_data, 10'h000);
    check("rst_underrun", underrun, 1'b0);
    check("rst_ready", s_ready, 1'b1);
    check("rst_level", fifo_level, 5'd0);

    // 2: prime and stream four samples
    push(10'h155);
    push(10'h2AA);
    push(10'h3FF);
    push(10'h001);
    check("prime_level", fifo_level, 5'd4);
    check("idle_pwrdn", dac_pwrdn, 1'b1);
    enable = 1'b1;
    tick(1);
    check("prime_pwrdn", dac_pwrdn, 1'b0);
    tick(1);
    tick(1);
    check("first_sample", dac_data, 10'h155);
    check("first_level", fifo_level, 5'd3);

    // 3: underrun on the fifth tick, clear, set again
    tick(15);
    check("pre_underrun", underrun, 1'b0);
    tick(1);
    check("underrun_set", underrun, 1'b1);
    check("underrun_hold", dac_data, 10'h001);
    check("underrun_level", fifo_level, 5'd0);
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    check("underrun_clr", underrun, 1'b0);
    tick(2);
    check("underrun_still_clr", underrun, 1'b0);
    tick(1);
    check("underrun_reset", underrun, 1'b1);
    enable = 1'b0;
    tick(3);
    check("run_until_wrap", dac_pwrdn, 1'b0);
    tick(1);
    check("stop_pwrdn", dac_pwrdn, 1'b1);
    check("stop_dclk", dac_dclkio, 1'b0);

    // 4: fill to full while idle, then restart
    acc = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      v = 10'h100 + 10'(i);
      s_data = v;
      rdy = s_ready;
      tick(1);
      if (rdy) begin
        acc++;
        exp_q.push_back(v);
      end
    end
    s_valid = 1'b0;
    check("fill_accepted", acc, 16);
    check("full_ready", s_ready, 1'b0);
    check("full_level", fifo_level, 5'd16);
    enable = 1'b1;
    tick(2);
    check("run_entry_ready", s_ready, 1'b0);
    tick(1);
    check("first_pop_ready", s_ready, 1'b1);
    check("first_pop_level", fifo_level, 5'd15);
    check("first_pop_data", dac_data, 10'h100);

    // 5: drop enable at cnt=1
    tick(1);
    enable = 1'b0;
    tick(2);
    check("late_stop_pwrdn", dac_pwrdn, 1'b0);
    check("late_stop_data", dac_data, 10'h100);
    check("late_stop_dclk", dac_dclkio, 1'b1);
    tick(1);
    check("stopped_pwrdn", dac_pwrdn, 1'b1);
    check("stopped_dclk", dac_dclkio, 1'b0);
    check("stopped_level", fifo_level, 5'd15);
    check("stopped_data", dac_data, 10'h100);

    // 6: async reset mid-RUN
    enable = 1'b1;
    tick(2);
    tick(8);
    check("pre_reset_level", fifo_level, 5'd13);
    check("pre_reset_data", dac_data, 10'h102);
    #3;
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("async_pwrdn", dac_pwrdn, 1'b1);
    check("async_dclk", dac_dclkio, 1'b0);
    check("async_data", dac_data, 10'h000);
    check("async_underrun", underrun, 1'b0);
    check("async_level", fifo_level, 5'd0);
    check("async_ready", s_ready, 1'b1);
    enable = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(2);
    check("post_reset_level", fifo_level, 5'd0);
    check("post_reset_pwrdn", dac_pwrdn, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
